// File: rtl/c499_key_ctrl.sv
// Key-load and word-sequencing controller for the locked c499 SEC core.
// Serially loads a 32-bit key, verifies its byte-fold signature, then meters words through the core.
module c499_key_ctrl #(
    parameter int KEY_W  = 32,
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_start,
    input  logic        key_sen,
    input  logic        key_sdi,
    input  logic [7:0]  key_sig,
    output logic [3:0]  p,
    output logic [27:0] x,
    output logic        key_ok,
    output logic        key_err,
    output logic        key_busy,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [40:0] in_data,
    output logic [40:0] core_in,
    input  logic [31:0] core_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK, S_ARMED} state_t;

    state_t           r_state, w_state_next;
    logic [5:0]       r_bit_cnt;
    logic [KEY_W-1:0] r_sreg;
    logic [KEY_W-1:0] r_key;
    logic             r_key_ok, r_key_err;
    logic             r_busy, r_out_valid;
    logic [3:0]       r_settle;
    logic [40:0]      r_core_in;
    logic [31:0]      r_out_data;

    logic [7:0]       w_fold;
    logic             w_sig_match, w_accept, w_start_load;

    assign w_fold      = r_sreg[31:24] ^ r_sreg[23:16] ^ r_sreg[15:8] ^ r_sreg[7:0];
    assign w_sig_match = (w_fold == key_sig);
    assign in_ready    = (r_state == S_ARMED) & ~r_busy & ~r_out_valid;
    assign w_accept    = in_valid & in_ready;

    always_comb begin
        // NOTE: defaults first so every path assigns every variable and no latch is inferred.
        w_state_next = r_state;
        w_start_load = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (key_start) begin
                    w_state_next = S_SHIFT;
                    w_start_load = 1'b1;
                end
            end
            S_SHIFT: begin
                if (key_start)
                    w_start_load = 1'b1;
                else if (key_sen && r_bit_cnt == 6'd31)
                    w_state_next = S_CHECK;
            end
            S_CHECK: w_state_next = w_sig_match ? S_ARMED : S_IDLE;
            S_ARMED: begin
                // A word handshake in the same cycle wins; the rekey request is dropped.
                if (key_start && in_ready && !in_valid) begin
                    w_state_next = S_SHIFT;
                    w_start_load = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // The core key only changes on a verified commit; a partial shift never reaches p/x.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_sreg    <= '0;
            r_key     <= '0;
            r_key_ok  <= 1'b0;
            r_key_err <= 1'b0;
        end else begin
            if (w_start_load) begin
                r_bit_cnt <= '0;
                r_key_ok  <= 1'b0;
                r_key_err <= 1'b0;
            end else if (r_state == S_SHIFT && key_sen) begin
                r_sreg    <= {key_sdi, r_sreg[KEY_W-1:1]};
                r_bit_cnt <= r_bit_cnt + 6'd1;
            end
            if (r_state == S_CHECK) begin
                if (w_sig_match) begin
                    r_key    <= r_sreg;
                    r_key_ok <= 1'b1;
                end else begin
                    r_key_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_core_in   <= '0;
            r_busy      <= 1'b0;
            r_settle    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (r_out_valid && out_ready)
                r_out_valid <= 1'b0;
            if (w_accept) begin
                r_core_in <= in_data;
                r_busy    <= 1'b1;
                r_settle  <= 4'(SETTLE);
            end else if (r_busy) begin
                if (r_settle == 4'd1) begin
                    r_out_data  <= core_out;
                    r_out_valid <= 1'b1;
                    r_busy      <= 1'b0;
                end
                r_settle <= r_settle - 4'd1;
            end
        end
    end

    assign p         = r_key[3:0];
    assign x         = r_key[KEY_W-1:4];
    assign key_ok    = r_key_ok;
    assign key_err   = r_key_err;
    assign key_busy  = (r_state == S_SHIFT) || (r_state == S_CHECK);
    assign core_in   = r_core_in;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_c499_key_ctrl.sv
// Randomised bench for c499_key_ctrl: key loads, word flow, backpressure, rekey and reset.
module tb_c499_key_ctrl;

    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_start = 1'b0, key_sen = 1'b0, key_sdi = 1'b0;
    logic [7:0]  key_sig = '0;
    logic [3:0]  p;
    logic [27:0] x;
    logic        key_ok, key_err, key_busy;
    logic        in_valid = 1'b0, in_ready;
    logic [40:0] in_data = '0, core_in;
    logic [31:0] core_out;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: committed key, flags and last word driven into the core.
    logic [31:0] m_key = '0;
    logic        m_ok = 1'b0, m_err = 1'b0;
    logic [40:0] m_core_in = '0;

    always #5 clk = ~clk;

    // Stand-in for the combinational locked core.
    assign core_out = core_in[31:0] ^ {x, p} ^ {23'd0, core_in[40:32]};

    c499_key_ctrl #(.KEY_W(32), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_start(key_start), .key_sen(key_sen), .key_sdi(key_sdi), .key_sig(key_sig),
        .p(p), .x(x), .key_ok(key_ok), .key_err(key_err), .key_busy(key_busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .core_in(core_in), .core_out(core_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    function automatic logic [7:0] f_fold(input logic [31:0] k);
        logic [7:0] f = 8'h00;
        for (int b = 0; b < 4; b++) f ^= k[8*b +: 8];
        return f;
    endfunction

    function automatic logic [31:0] f_core(input logic [40:0] d, input logic [31:0] k);
        return d[31:0] ^ k ^ {23'd0, d[40:32]};
    endfunction

    task automatic test_reset_state(input string tag);
        n_checks++;
        if ({x, p} !== 32'd0) begin
            n_fail++; $display("FAIL %s key: got %h want 0", tag, {x, p});
        end
        n_checks++;
        if ({core_in, out_data} !== 73'd0) begin
            n_fail++; $display("FAIL %s data: core_in=%h out_data=%h want 0", tag, core_in, out_data);
        end
        n_checks++;
        if ({out_valid, in_ready, key_ok, key_err, key_busy} !== 5'd0) begin
            n_fail++; $display("FAIL %s flags: got %b want 00000", tag,
                               {out_valid, in_ready, key_ok, key_err, key_busy});
        end
    endtask

    task automatic test_reset;
        #3 test_reset_state("reset");
        #9 rst_n = 1'b1;
    endtask

    task automatic load_key(input logic [31:0] k, input logic [7:0] sig, input int gap_max);
        @(negedge clk);
        key_start = 1'b1;
        key_sig   = sig;
        @(posedge clk); #1;
        m_ok = 1'b0; m_err = 1'b0;
        n_checks++;
        if ({key_busy, key_ok, key_err} !== 3'b100) begin
            n_fail++; $display("FAIL load_start busy/ok/err: got %b want 100", {key_busy, key_ok, key_err});
        end
        @(negedge clk);
        key_start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                key_sen = 1'b0; key_sdi = 1'($urandom); @(negedge clk);
            end
            key_sen = 1'b1; key_sdi = k[i];
            @(negedge clk);
            if (i == 16) begin
                n_checks++;
                if ({x, p, key_ok, in_ready} !== {m_key, 2'b00}) begin
                    n_fail++; $display("FAIL mid_shift key/ok/ready: got %h %b %b want %h 0 0",
                                       {x, p}, key_ok, in_ready, m_key);
                end
            end
        end
        n_checks++;
        if ({key_busy, key_ok, x, p} !== {2'b10, m_key}) begin
            n_fail++; $display("FAIL check_cycle busy/ok/key: got %b %b %h want 1 0 %h",
                               key_busy, key_ok, {x, p}, m_key);
        end
        key_sen = 1'($urandom); key_sdi = 1'($urandom);
        @(posedge clk); #1;
        if (f_fold(k) == sig) begin m_key = k; m_ok = 1'b1; end
        else                  begin m_err = 1'b1; end
        n_checks++;
        if ({key_ok, key_err, key_busy, in_ready} !== {m_ok, m_err, 1'b0, m_ok}) begin
            n_fail++; $display("FAIL commit ok/err/busy/ready: got %b want %b",
                               {key_ok, key_err, key_busy, in_ready}, {m_ok, m_err, 1'b0, m_ok});
        end
        n_checks++;
        if ({x, p} !== m_key || core_in !== m_core_in) begin
            n_fail++; $display("FAIL commit key/core_in: got %h %h want %h %h", {x, p}, core_in, m_key, m_core_in);
        end
        @(negedge clk);
        key_sen = 1'b0;
    endtask

    task automatic send_word(input logic [40:0] d, input int bp, input bit rekey_busy);
        logic [31:0] exp;
        int w = 0;
        @(negedge clk);
        out_ready = (bp == 0);
        while (!in_ready && w < 20) begin @(negedge clk); w++; end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL word_ready_timeout: in_ready=%b want 1", in_ready);
            return;
        end
        in_valid = 1'b1; in_data = d;
        @(posedge clk); #1;
        m_core_in = d;
        exp = f_core(d, m_key);
        n_checks++;
        if (core_in !== d || {in_ready, out_valid} !== 2'b00) begin
            n_fail++; $display("FAIL accept core_in/ready/valid: got %h %b %b want %h 0 0",
                               core_in, in_ready, out_valid, d);
        end
        @(negedge clk);
        in_valid = 1'b0; in_data = 41'({$urandom, $urandom});
        if (rekey_busy) key_start = 1'b1;
        for (int c = 1; c < SETTLE; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b0 || core_in !== m_core_in) begin
                n_fail++; $display("FAIL settle valid/core_in: got %b %h want 0 %h", out_valid, core_in, m_core_in);
            end
            @(negedge clk);
            key_start = 1'b0;
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== exp) begin
            n_fail++; $display("FAIL result valid/data: got %b %h want 1 %h", out_valid, out_data, exp);
        end
        n_checks++;
        if ({key_busy, key_ok} !== 2'b01) begin
            n_fail++; $display("FAIL result busy/ok: got %b want 01", {key_busy, key_ok});
        end
        @(negedge clk);
        key_start = 1'b0;
        for (int j = 0; j < bp; j++) begin
            n_checks++;
            if ({out_valid, in_ready} !== 2'b10 || out_data !== exp) begin
                n_fail++; $display("FAIL backpressure valid/ready/data: got %b %b %h want 1 0 %h",
                                   out_valid, in_ready, out_data, exp);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL release valid/ready: got %b want 01", {out_valid, in_ready});
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_bad_key;
        load_key(32'h12345678, 8'h09, 0);
        n_checks++;
        if ({key_err, key_ok, in_ready, x, p} !== {3'b100, 32'd0}) begin
            n_fail++; $display("FAIL bad_key err/ok/ready/key: got %b %b %b %h want 1 0 0 0",
                               key_err, key_ok, in_ready, {x, p});
        end
    endtask

    task automatic test_good_key;
        load_key(32'h12345678, 8'h08, 0);
        n_checks++;
        if (p !== 4'h8 || x !== 28'h1234567 || key_err !== 1'b0) begin
            n_fail++; $display("FAIL good_key p/x/err: got %h %h %b want 8 1234567 0", p, x, key_err);
        end
    endtask

    task automatic test_word_flow;
        send_word(41'h0AAAAAAAA5, 0, 1'b0);
        for (int i = 0; i < 4; i++) send_word(41'({$urandom, $urandom}), 0, 1'b0);
    endtask

    task automatic test_backpressure;
        send_word(41'({$urandom, $urandom}), 5, 1'b0);
        send_word(41'({$urandom, $urandom}), 2, 1'b0);
    endtask

    task automatic test_rekey_busy;
        send_word(41'({$urandom, $urandom}), 1, 1'b1);
        load_key(32'hCAFEF00D, f_fold(32'hCAFEF00D), 1);
        send_word(41'({$urandom, $urandom}), 0, 1'b0);
    endtask

    task automatic test_random_keys;
        logic [31:0] k;
        logic [7:0]  sig;
        for (int i = 0; i < 6; i++) begin
            k   = $urandom;
            sig = ($urandom_range(0, 1) == 1) ? f_fold(k) : (f_fold(k) ^ 8'($urandom_range(1, 255)));
            load_key(k, sig, 2);
            if (m_ok)
                for (int j = 0; j < 3; j++)
                    send_word(41'({$urandom, $urandom}), $urandom_range(0, 3), 1'b0);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        key_start = 1'b1;
        @(negedge clk);
        key_start = 1'b0;
        for (int i = 0; i < 17; i++) begin
            key_sen = 1'b1; key_sdi = 1'($urandom); @(negedge clk);
        end
        key_sen = 1'b0;
        #2 rst_n = 1'b0;
        #1 test_reset_state("reset_mid_shift");
        m_key = '0; m_ok = 1'b0; m_err = 1'b0; m_core_in = '0;
        @(negedge clk);
        rst_n = 1'b1;
        load_key(32'h0BADBEEF, f_fold(32'h0BADBEEF), 0);
        send_word(41'({$urandom, $urandom}), 0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; in_data = 41'h1F0F0F0F0F0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 test_reset_state("reset_mid_word");
        m_key = '0; m_ok = 1'b0; m_err = 1'b0; m_core_in = '0;
        @(negedge clk);
        rst_n = 1'b1;
        load_key(32'h12345678, 8'h08, 1);
        send_word(41'({$urandom, $urandom}), 1, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_bad_key();
        test_good_key();
        test_word_flow();
        test_backpressure();
        test_rekey_busy();
        test_random_keys();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
